// File: rtl/impulse_accumulator_pkg.sv
// ----------------------------------------------------------------------------
// impulse_accumulator_pkg
// Shared definitions for the impulse accumulator: FSM state encoding,
// impulse-word field positions, read-word kind constants, end-of-list value
// and multiply pipeline widths.
// ----------------------------------------------------------------------------
package impulse_accumulator_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_IMP = 3'd1,
        ST_WAIT_SMP = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_EMIT     = 3'd4
    } state_e;

    // Impulse word layout: [15:13] top offset, [12:9] bottom offset,
    // [8] negative, [7:0] unsigned Q0.8 coefficient
    localparam int IMP_TOP_MSB  = 15;
    localparam int IMP_TOP_LSB  = 13;
    localparam int IMP_BOT_MSB  = 12;
    localparam int IMP_BOT_LSB  = 9;
    localparam int IMP_NEG_BIT  = 8;
    localparam int IMP_COEF_MSB = 7;
    localparam int IMP_COEF_LSB = 0;

    // rd_kind encoding
    localparam logic RD_KIND_IMP = 1'b0;
    localparam logic RD_KIND_SMP = 1'b1;

    // An all-zero impulse word terminates the list for the period
    localparam logic [15:0] END_OF_LIST = 16'h0000;

    // signed 16-bit sample times {1'b0, 8-bit coef}
    localparam int PROD_W = 25;

    // Output is the accumulator scaled back by the Q0.8 coefficient
    localparam int OUT_SHIFT = 8;

endpackage

// File: rtl/impulse_accumulator_mac.sv
// ----------------------------------------------------------------------------
// impulse_mac
// Two-stage multiply/accumulate.
//   stage 1: registers signed(sample) * {1'b0,coef} as a 25-bit product
//   stage 2: adds (or subtracts when negative) the sign-extended product
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   i_clear      synchronous clear of accumulator and stage-1 valid
//   i_valid      issue one multiply this cycle
//   i_sample     signed 16-bit delayed sample
//   i_coef       unsigned Q0.8 coefficient
//   i_neg        subtract the product instead of adding it
//   o_acc        accumulator value
//   o_busy       a product is still in flight
// ----------------------------------------------------------------------------
module impulse_mac
    import impulse_accumulator_pkg::*;
#(
    parameter int ACC_W = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [15:0]      i_sample,
    input  logic [7:0]       i_coef,
    input  logic             i_neg,
    output logic [ACC_W-1:0] o_acc,
    output logic             o_busy
);

    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] r_prod;
    logic                     r_s1_neg;
    logic                     r_s1_valid;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_prod_ext;

    // Zero-extended coefficient keeps the multiply signed without flipping sign
    assign w_prod     = $signed(i_sample) * $signed({1'b0, i_coef});
    assign w_prod_ext = {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};

    // Stage 1: product register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod     <= '0;
            r_s1_neg   <= 1'b0;
            r_s1_valid <= 1'b0;
        end else if (i_clear) begin
            r_prod     <= '0;
            r_s1_neg   <= 1'b0;
            r_s1_valid <= 1'b0;
        end else begin
            r_prod     <= w_prod;
            r_s1_neg   <= i_neg;
            r_s1_valid <= i_valid;
        end
    end

    // Stage 2: accumulate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (r_s1_valid) begin
            if (r_s1_neg) begin
                r_acc <= r_acc - w_prod_ext;
            end else begin
                r_acc <= r_acc + w_prod_ext;
            end
        end else begin
            r_acc <= r_acc;
        end
    end

    assign o_acc  = r_acc;
    assign o_busy = r_s1_valid;

endmodule

// File: rtl/impulse_accumulator.sv
// ----------------------------------------------------------------------------
// impulse_accumulator
// Per audio sample period, accumulates impulse-coefficient x delayed-sample
// products streamed from memory and emits the scaled wet result.
// Ports:
//   clk          system clock (rising edge)
//   rst_n        asynchronous active-low reset (release synchronised to clk)
//   sample_tick  start of a new sample period
//   rd_valid     rd_data holds a memory word
//   rd_kind      0 = impulse word, 1 = delayed-sample word
//   rd_data      memory word
//   audio_out    signed wet result of the last completed period
//   out_valid    one-cycle pulse when audio_out updates
//   tap_count    pairs accumulated in the last completed period
//   seq_err      sticky out-of-order word flag, cleared only by reset
// Configuration macro:
//   IMPULSE_ACC_SAT_EN  defined: saturate audio_out to the signed 16-bit range
//                       undefined: audio_out = acc[23:8] (wrap)
// ----------------------------------------------------------------------------
module impulse_accumulator
    import impulse_accumulator_pkg::*;
#(
    parameter int MAX_TAPS = 511,
    parameter int ACC_W    = 34
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_tick,
    input  logic        rd_valid,
    input  logic        rd_kind,
    input  logic [15:0] rd_data,
    output logic [15:0] audio_out,
    output logic        out_valid,
    output logic [9:0]  tap_count,
    output logic        seq_err
);

    localparam logic [9:0] MAX_TAPS_C = 10'(MAX_TAPS);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    state_e           r_state;
    logic [7:0]       r_coef;
    logic             r_neg;
    logic [9:0]       r_pairs;
    logic             r_tick_pend;
    logic             w_issue;
    logic             w_clear;
    logic             w_busy;
    logic [ACC_W-1:0] w_acc;
    logic [15:0]      w_audio_next;
    logic             w_is_imp;
    logic             w_is_smp;
    logic             w_is_eol;

    // Reset synchroniser: asserts asynchronously, releases on clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n  = r_rst_sync[1];

    assign w_is_imp = rd_valid && (rd_kind == RD_KIND_IMP);
    assign w_is_smp = rd_valid && (rd_kind == RD_KIND_SMP);
    assign w_is_eol = (rd_data == END_OF_LIST);

    // Pairs past the tap limit complete the handshake but never reach the MAC
    assign w_issue = (r_state == ST_WAIT_SMP) && w_is_smp && !sample_tick
                     && (r_pairs < MAX_TAPS_C);
    assign w_clear = (r_state == ST_IDLE) && (sample_tick || r_tick_pend);

`ifdef IMPULSE_ACC_SAT_EN
    // Clamp acc >>> 8 to the signed 16-bit range
    function automatic logic [15:0] sat_out(input logic [ACC_W-1:0] acc);
        logic [ACC_W-24:0] hi;
        hi = acc[ACC_W-1:23];
        if ((&hi) || (~|hi)) begin
            return acc[23:8];
        end else if (acc[ACC_W-1]) begin
            return 16'h8000;
        end else begin
            return 16'h7FFF;
        end
    endfunction

    logic [7:0] w_unused_acc;
    assign w_unused_acc = w_acc[OUT_SHIFT-1:0];
    assign w_audio_next = sat_out(w_acc);
`else
    logic [ACC_W-17:0] w_unused_acc;
    assign w_unused_acc = {w_acc[ACC_W-1:24], w_acc[OUT_SHIFT-1:0]};
    assign w_audio_next = w_acc[23:8];
`endif

    impulse_mac #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst_n    (w_rst_n),
        .i_clear  (w_clear),
        .i_valid  (w_issue),
        .i_sample (rd_data),
        .i_coef   (r_coef),
        .i_neg    (r_neg),
        .o_acc    (w_acc),
        .o_busy   (w_busy)
    );

    // Period sequencer with registered outputs
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_IDLE;
            r_coef      <= 8'h00;
            r_neg       <= 1'b0;
            r_pairs     <= 10'd0;
            r_tick_pend <= 1'b0;
            audio_out   <= 16'h0000;
            out_valid   <= 1'b0;
            tap_count   <= 10'd0;
            seq_err     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sample_tick || r_tick_pend) begin
                        r_pairs     <= 10'd0;
                        r_tick_pend <= 1'b0;
                        r_state     <= ST_WAIT_IMP;
                    end
                end
                ST_WAIT_IMP: begin
                    if (sample_tick) begin
                        // Early tick: finish this period, then start the next
                        r_tick_pend <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end else if (w_is_imp) begin
                        if (w_is_eol) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_coef  <= rd_data[IMP_COEF_MSB:IMP_COEF_LSB];
                            r_neg   <= rd_data[IMP_NEG_BIT];
                            r_state <= ST_WAIT_SMP;
                        end
                    end else if (w_is_smp) begin
                        seq_err <= 1'b1;
                    end
                end
                ST_WAIT_SMP: begin
                    if (sample_tick) begin
                        r_tick_pend <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end else if (w_is_smp) begin
                        if (w_issue) begin
                            r_pairs <= r_pairs + 10'd1;
                        end
                        r_state <= ST_WAIT_IMP;
                    end else if (w_is_imp) begin
                        seq_err <= 1'b1;
                        // An end marker here still closes the list
                        if (w_is_eol) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_coef <= rd_data[IMP_COEF_MSB:IMP_COEF_LSB];
                            r_neg  <= rd_data[IMP_NEG_BIT];
                        end
                    end
                end
                ST_DRAIN: begin
                    if (sample_tick) begin
                        r_tick_pend <= 1'b1;
                    end
                    if (!w_busy) begin
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (sample_tick) begin
                        r_tick_pend <= 1'b1;
                    end
                    audio_out <= w_audio_next;
                    tap_count <= r_pairs;
                    out_valid <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_impulse_accumulator.sv
module tb_impulse_accumulator;

    logic        clk;
    logic        rst_n;
    logic        sample_tick;
    logic        rd_valid;
    logic        rd_kind;
    logic [15:0] rd_data;
    logic [15:0] audio_out;
    logic        out_valid;
    logic [9:0]  tap_count;
    logic        seq_err;

    int checks;
    int errors;

    impulse_accumulator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .rd_valid    (rd_valid),
        .rd_kind     (rd_kind),
        .rd_data     (rd_data),
        .audio_out   (audio_out),
        .out_valid   (out_valid),
        .tap_count   (tap_count),
        .seq_err     (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All drivers assume they start at a negedge and end at a negedge
    task automatic tick();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic word(input logic k, input logic [15:0] d);
        rd_valid = 1'b1;
        rd_kind  = k;
        rd_data  = d;
        @(negedge clk);
        rd_valid = 1'b0;
        rd_data  = 16'h0000;
    endtask

    task automatic wait_out(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic period_check(input string name, input logic [15:0] exp_a,
                                input logic [9:0] exp_t);
        bit seen;
        wait_out(seen);
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid timeout got=0 exp=1", name);
        end
        checks++;
        if (audio_out !== exp_a) begin
            errors++;
            $display("FAIL %s audio_out got=%h exp=%h", name, audio_out, exp_a);
        end
        checks++;
        if (tap_count !== exp_t) begin
            errors++;
            $display("FAIL %s tap_count got=%0d exp=%0d", name, tap_count, exp_t);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sample_tick = 1'b0;
        rd_valid = 1'b0;
        rd_kind = 1'b0;
        rd_data = 16'h0000;
        repeat (3) @(negedge clk);
        checks++;
        if ({audio_out, out_valid, tap_count, seq_err} !== 28'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h/%b/%0d/%b exp=0",
                     audio_out, out_valid, tap_count, seq_err);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        tick();
        word(1'b0, 16'h0080);
        word(1'b1, 16'h1000);
        word(1'b0, 16'h0000);
        period_check("basic", 16'h0800, 10'd1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (seq_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_seq_err got=%b exp=0", seq_err);
        end
    endtask

    task automatic test_negative_sample();
        tick();
        word(1'b0, 16'h0080);
        word(1'b1, 16'hF000);
        word(1'b0, 16'h0000);
        period_check("neg_sample", 16'hF800, 10'd1);
    endtask

    task automatic test_cancel();
        tick();
        word(1'b0, 16'h0140);
        word(1'b1, 16'h0100);
        word(1'b0, 16'h0040);
        word(1'b1, 16'h0100);
        word(1'b0, 16'h0000);
        period_check("cancel", 16'h0000, 10'd2);
    endtask

    task automatic test_saturate();
        tick();
        for (int i = 0; i < 4; i++) begin
            word(1'b0, 16'h00FF);
            word(1'b1, 16'h7FFF);
        end
        word(1'b0, 16'h0000);
`ifdef IMPULSE_ACC_SAT_EN
        period_check("sat_pos", 16'h7FFF, 10'd4);
`else
        period_check("sat_pos", 16'hFDFC, 10'd4);
`endif
        tick();
        for (int i = 0; i < 4; i++) begin
            word(1'b0, 16'h00FF);
            word(1'b1, 16'h8000);
        end
        word(1'b0, 16'h0000);
`ifdef IMPULSE_ACC_SAT_EN
        period_check("sat_neg", 16'h8000, 10'd4);
`else
        period_check("sat_neg", 16'h0200, 10'd4);
`endif
    endtask

    task automatic test_tick_abort();
        tick();
        word(1'b0, 16'h0080);
        tick();
        period_check("abort_partial", 16'h0000, 10'd0);
        // New period opened by the held tick
        word(1'b0, 16'h0080);
        word(1'b1, 16'h0200);
        word(1'b0, 16'h0000);
        period_check("abort_fresh", 16'h0100, 10'd1);
    endtask

    task automatic test_idle_ignore();
        word(1'b0, 16'h0080);
        word(1'b1, 16'h1000);
        tick();
        word(1'b0, 16'h0000);
        period_check("idle_ignore", 16'h0000, 10'd0);
    endtask

    task automatic test_max_taps();
        tick();
        for (int i = 0; i < 515; i++) begin
            word(1'b0, 16'h0001);
            word(1'b1, 16'h0100);
        end
        word(1'b0, 16'h0000);
        period_check("max_taps", 16'h01FF, 10'd511);
        checks++;
        if (seq_err !== 1'b0) begin
            errors++;
            $display("FAIL max_taps_seq_err got=%b exp=0", seq_err);
        end
    endtask

    task automatic test_seq_err();
        tick();
        word(1'b1, 16'h1234);
        checks++;
        if (seq_err !== 1'b1) begin
            errors++;
            $display("FAIL seq_err_set got=%b exp=1", seq_err);
        end
        word(1'b0, 16'h0080);
        word(1'b1, 16'h1000);
        word(1'b0, 16'h0000);
        period_check("seq_err_period", 16'h0800, 10'd1);
        // Second impulse replaces the latched coefficient
        tick();
        word(1'b0, 16'h0010);
        word(1'b0, 16'h0080);
        word(1'b1, 16'h1000);
        word(1'b0, 16'h0000);
        period_check("replace_coef", 16'h0800, 10'd1);
        checks++;
        if (seq_err !== 1'b1) begin
            errors++;
            $display("FAIL seq_err_sticky got=%b exp=1", seq_err);
        end
    endtask

    task automatic test_reset_mid_period();
        bit seen;
        tick();
        word(1'b0, 16'h0080);
        word(1'b1, 16'h1000);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({audio_out, out_valid, tap_count, seq_err} !== 28'h0) begin
            errors++;
            $display("FAIL midreset_outputs got=%h/%b/%0d/%b exp=0",
                     audio_out, out_valid, tap_count, seq_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        word(1'b0, 16'h0000);
        wait_out(seen);
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_out got=1 exp=0");
        end
        checks++;
        if ({audio_out, tap_count, seq_err} !== 27'h0) begin
            errors++;
            $display("FAIL midreset_after got=%h/%0d/%b exp=0",
                     audio_out, tap_count, seq_err);
        end
        tick();
        word(1'b0, 16'h0080);
        word(1'b1, 16'h0400);
        word(1'b0, 16'h0000);
        period_check("after_reset", 16'h0200, 10'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_negative_sample();
        test_cancel();
        test_saturate();
        test_tick_abort();
        test_idle_ignore();
        test_max_taps();
        test_seq_err();
        test_reset_mid_period();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
